// File: rtl/difftest_aia_pkg.sv
// Shared types for the AIA difftest event queue: the interrupt-state
// snapshot carried through the FIFO, and the field width.
package difftest_aia_pkg;

  localparam int AIA_FIELD_W = 64;
  localparam int AIA_KEY_W   = 4 * AIA_FIELD_W;

  typedef struct packed {
    logic [AIA_FIELD_W-1:0] mtopei;
    logic [AIA_FIELD_W-1:0] stopei;
    logic [AIA_FIELD_W-1:0] vstopei;
    logic [AIA_FIELD_W-1:0] hgeip;
    logic [7:0]             coreid;
  } aia_snapshot_t;

  // Fields that participate in change detection (coreid excluded).
  function automatic logic [AIA_KEY_W-1:0] aia_key(input aia_snapshot_t s);
    return {s.mtopei, s.stopei, s.vstopei, s.hgeip};
  endfunction

endpackage

// File: rtl/difftest_sync_fifo.sv
// Generic first-word-fall-through FIFO with an overwrite-newest port.
// Pointers carry one extra wrap bit so full/empty need no separate counter.
// rdata reads zero while empty so downstream sees clean fields after reset.
module difftest_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             ovw,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [LW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW-1:0]    newest_idx;
  logic             pop_ok, push_ok;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign level = wr_q - rd_q;
  assign rdata = empty ? '0 : mem[rd_q[AW-1:0]];

  // Pointer next-state; a push into a full FIFO is legal only alongside a pop.
  always_comb begin
    pop_ok     = pop & ~empty;
    push_ok    = push & (~full | pop_ok);
    wr_d       = wr_q + LW'(push_ok);
    rd_d       = rd_q + LW'(pop_ok);
    newest_idx = wr_q[AW-1:0] - AW'(1);
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage: normal write at the tail, or replace the most recent entry.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_q[AW-1:0]] <= wdata;
    else if (ovw && !empty)
      mem[newest_idx] <= wdata;
  end

endmodule

// File: rtl/difftest_aia_event_queue.sv
// AIA difftest event producer: enqueues the core's interrupt-state snapshot
// whenever it changes, buffers it through a small FWFT FIFO, and coalesces
// into the newest entry (counting drops) when the sink back-pressures.
// Optional macro DIFFTEST_AIA_EVENT_TIMESTAMP_EN adds a 64-bit cycle stamp
// per entry and the out_stamp port.
module difftest_aia_event_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    in_valid,
  input  logic [63:0]             in_mtopei,
  input  logic [63:0]             in_stopei,
  input  logic [63:0]             in_vstopei,
  input  logic [63:0]             in_hgeip,
  input  logic [7:0]              in_coreid,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [63:0]             out_mtopei,
  output logic [63:0]             out_stopei,
  output logic [63:0]             out_vstopei,
  output logic [63:0]             out_hgeip,
  output logic [7:0]              out_coreid,
`ifdef DIFFTEST_AIA_EVENT_TIMESTAMP_EN
  output logic [63:0]             out_stamp,
`endif
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic [CNT_W-1:0]        drop_cnt
);
  import difftest_aia_pkg::*;

  localparam int SNAP_W = $bits(aia_snapshot_t);
`ifdef DIFFTEST_AIA_EVENT_TIMESTAMP_EN
  localparam int EW = SNAP_W + 64;
`else
  localparam int EW = SNAP_W;
`endif

  aia_snapshot_t          snap_in, snap_out;
  logic [AIA_KEY_W-1:0]   last_q, last_d;
  logic                   primed_q, primed_d;
  logic                   overflow_q, overflow_d;
  logic [CNT_W-1:0]       drop_q, drop_d;
  logic                   push_req, pop, coalesce, fifo_push;
  logic                   full, empty;
  logic [EW-1:0]          wdata, rdata;

  assign snap_in = '{mtopei: in_mtopei, stopei: in_stopei, vstopei: in_vstopei,
                     hgeip: in_hgeip, coreid: in_coreid};

`ifdef DIFFTEST_AIA_EVENT_TIMESTAMP_EN
  logic [63:0] stamp_q, stamp_d;

  // Free-running cycle counter; wraps.
  always_comb stamp_d = stamp_q + 64'd1;

  // Cycle counter register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) stamp_q <= '0;
    else          stamp_q <= stamp_d;
  end

  assign wdata     = {stamp_q, snap_in};
  assign snap_out  = rdata[SNAP_W-1:0];
  assign out_stamp = rdata[EW-1:SNAP_W];
`else
  assign wdata    = snap_in;
  assign snap_out = rdata;
`endif

  // Change detect, push/coalesce decision and drop accounting.
  always_comb begin
    last_d     = last_q;
    primed_d   = primed_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    pop        = ~empty & out_ready;
    push_req   = in_valid & (~primed_q | (aia_key(snap_in) != last_q));
    fifo_push  = push_req & (~full | pop);
    coalesce   = push_req & full & ~pop;
    // Last-seen tracks every change, even ones that end up coalesced.
    if (push_req) begin
      last_d   = aia_key(snap_in);
      primed_d = 1'b1;
    end
    if (coalesce) begin
      overflow_d = 1'b1;
      if (drop_q != '1) drop_d = drop_q + CNT_W'(1);
    end
  end

  // Change-detect and status registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_q     <= '0;
      primed_q   <= 1'b0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      last_q     <= last_d;
      primed_q   <= primed_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  difftest_sync_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) u_fifo (
    .clk   (clock),
    .rst_n (reset_n),
    .push  (fifo_push),
    .pop   (pop),
    .ovw   (coalesce),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign out_valid   = ~empty;
  assign out_mtopei  = snap_out.mtopei;
  assign out_stopei  = snap_out.stopei;
  assign out_vstopei = snap_out.vstopei;
  assign out_hgeip   = snap_out.hgeip;
  assign out_coreid  = snap_out.coreid;
  assign overflow    = overflow_q;
  assign drop_cnt    = drop_q;

endmodule

// File: doc/difftest_aia_event_queue.md
Name: difftest_aia_event_queue

Overview:
- Upstream producer for the per-core AIA difftest sink.
- Watches the core's AIA interrupt-state snapshot: mtopei, stopei, vstopei, hgeip.
- Enqueues a snapshot only when it differs from the last enqueued one, in a small FWFT FIFO.
- Drains one entry per accepted out_valid/out_ready beat; the sink's enable is driven by out_valid & out_ready.
- Bursts of changes survive sink back-pressure; overflow is coalesced and counted.

Parameters:
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- CNT_W, 16: width of the saturating drop counter.

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous assert, active-low; deassertion is synchronised externally.
- in_valid  in  1  snapshot below is meaningful this cycle.
- in_mtopei  in  64  machine top external interrupt.
- in_stopei  in  64  supervisor top external interrupt.
- in_vstopei  in  64  virtual supervisor top external interrupt.
- in_hgeip  in  64  guest external interrupt pending.
- in_coreid  in  8  hart id, stored with each entry.
- out_valid  out  1  head entry is available.
- out_ready  in  1  sink accepts the head this cycle.
- out_mtopei, out_stopei, out_vstopei, out_hgeip  out  64 each  head entry fields.
- out_coreid  out  8  head entry core id.
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky; set on the first coalesce.
- drop_cnt  out  CNT_W  count of coalesced (lost) snapshots; saturates.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - rd/wr pointers=0, level=0, out_valid=0, overflow=0, drop_cnt=0.
  - All out_* data fields read 0.
  - last-snapshot register=0, primed=0.
  - Storage contents are don't-care.
- Change detect:
  - push_req = in_valid & (~primed | {mtopei,stopei,vstopei,hgeip} != last).
  - in_coreid does not participate in the compare.
  - On push_req: last <= the input fields and primed <= 1, regardless of FIFO space.
  - Consequence: the first valid snapshot after reset is always enqueued, even if all zero.
- FIFO:
  - Pointers are $clog2(DEPTH)+1 bits, wrapping naturally.
  - empty when pointers are equal; full when the MSBs differ and the rest are equal.
  - level = wr - rd.
  - out_valid = ~empty. out_* is driven from mem[rd] combinationally (FWFT).
- Latency: snapshot accepted at edge N appears on out_* with out_valid=1 in cycle N+1. There is no same-cycle bypass.
- pop = out_valid & out_ready; rd advances at the edge.
- out_ready while empty: ignored, no state change.
- Simultaneous push and pop:
  - Both take effect and level is unchanged. This holds including when full.
  - When empty, push wins; pop is not possible.
- Full & push_req & ~pop (coalesce):
  - The newest entry mem[wr-1] is overwritten with the incoming snapshot; pointers unchanged.
  - drop_cnt increments, saturating at 2^CNT_W-1.
  - overflow <= 1.
  - When DEPTH=1-equivalent conditions hold (rd == wr-1 while out_valid), the head is overwritten. This is allowed because no pop occurs that cycle.
- out_* must hold stable while out_valid=1 & out_ready=0, unless a coalesce targets the head. That only occurs when level==1, which cannot be full for DEPTH>=2, so out_* is always stable for legal DEPTH.
- Reset mid-operation: all queued entries are discarded. The next valid snapshot re-enqueues because primed=0.

Optional Feature:
- Macro: DIFFTEST_AIA_EVENT_TIMESTAMP_EN.
- When defined:
  - Adds a free-running 64-bit cycle counter (reset 0, wraps).
  - Each entry stores the counter value at its push edge.
  - A coalesce overwrites the stamp too.
  - Adds output out_stamp [63:0], head entry stamp.
- When undefined: no counter, no port, no extra storage.

Decomposition:
- Shared package difftest_aia_pkg holds:
  - typedef aia_snapshot_t (mtopei, stopei, vstopei, hgeip, coreid).
  - Constant AIA_FIELD_W=64.
- One sub-module, difftest_sync_fifo: generic FWFT FIFO with push/pop/full/empty/level and an overwrite-newest port.
- The top-level block holds change detect, coalesce control and counters.

Test Plan:
- Single change: reset, then in_valid=1 with mtopei=0x0B for 1 cycle, out_ready=1 → next cycle out_valid=1, out_mtopei=0x0B, level=1; following cycle level=0.
- Duplicate suppression: same snapshot held valid for 10 cycles → exactly one entry enqueued. A hgeip change 0x0→0x4 enqueues a second entry.
- Back-pressure burst: out_ready=0, 4 distinct snapshots (mtopei=1..4), DEPTH=4 → level=4, head mtopei=1 stable, overflow=0.
- Coalesce: continue with mtopei=5,6 while full → level=4, drop_cnt=2, overflow=1. Draining yields mtopei 1,2,3,6.
- Full push+pop: full, out_ready=1, new mtopei=7 → level stays 4, drop_cnt unchanged, 7 is the last entry drained.
- Async reset mid-burst: reset_n=0 for half a cycle with level=3 → out_valid=0 immediately. After release, an all-zero valid snapshot is enqueued (primed=0).
